// File: rtl/tick_period_meter_pkg.sv
// Shared FSM encoding and default sizing for tick_period_meter and its synchroniser.
// Optional majority filter enabled by TICK_METER_GLITCH_FILTER_EN (see tick_sync_edge).
package tick_period_meter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int unsigned DEF_CNT_W      = 27;
  localparam int unsigned DEF_MIN_PERIOD = 4;
  localparam int unsigned STD_DIV_PERIOD = 360000;
  // Allow one full missed tick of the standard divider before declaring loss of signal.
  localparam int unsigned DEF_MAX_PERIOD = 2 * STD_DIV_PERIOD;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/tick_sync_edge.sv
// Two-flop synchroniser plus edge detector for the measured square wave.
// With TICK_METER_GLITCH_FILTER_EN defined, a 3-sample majority filter drops 1-clock pulses.
module tick_sync_edge
  import tick_period_meter_pkg::*;
(
  input  logic clock_in,
  input  logic reset_n,
  input  logic i_sig,
  output logic o_rise,
  output logic o_fall
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic w_filt;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_sig;
      r_sync2 <= r_sync1;
    end
  end

`ifdef TICK_METER_GLITCH_FILTER_EN
  logic r_hist0;
  logic r_hist1;
  logic r_filt;

  // Majority of the current and two previous synchronised samples, registered.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_hist0 <= 1'b0;
      r_hist1 <= 1'b0;
      r_filt  <= 1'b0;
    end else begin
      r_hist0 <= r_sync2;
      r_hist1 <= r_hist0;
      r_filt  <= majority3(r_sync2, r_hist0, r_hist1);
    end
  end

  assign w_filt = r_filt;
`else
  assign w_filt = r_sync2;
`endif

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_filt;
    end
  end

  assign o_rise = w_filt & ~r_prev;
  assign o_fall = ~w_filt & r_prev;

endmodule

// File: rtl/tick_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in system clocks,
// with glitch rejection and sticky timeout. Optional filter: TICK_METER_GLITCH_FILTER_EN.
module tick_period_meter
  import tick_period_meter_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned MIN_PERIOD = DEF_MIN_PERIOD,
  parameter int unsigned MAX_PERIOD = DEF_MAX_PERIOD
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             sig_in,
  output logic             tick,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             valid,
  output logic             locked,
  output logic             glitch,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  logic             w_rise;
  logic             w_fall;

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hi_cap;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high;
  logic             r_tick;
  logic             r_valid;
  logic             r_locked;
  logic             r_glitch;
  logic             r_timeout;

  tick_sync_edge u_sync (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .i_sig    (sig_in),
    .o_rise   (w_rise),
    .o_fall   (w_fall)
  );

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_hi_cap  <= '0;
      r_period  <= '0;
      r_high    <= '0;
      r_tick    <= 1'b0;
      r_valid   <= 1'b0;
      r_locked  <= 1'b0;
      r_glitch  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_tick   <= w_rise;
      r_valid  <= 1'b0;
      r_glitch <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_state   <= ST_RUN;
            r_cnt     <= ONE_CNT;
            r_hi_cap  <= '0;
            r_timeout <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_rise) begin
            if (r_cnt >= MIN_CNT) begin
              r_period <= r_cnt;
              r_high   <= r_hi_cap;
              r_valid  <= 1'b1;
              r_locked <= 1'b1;
            end else begin
              r_glitch <= 1'b1;
              r_locked <= 1'b0;
            end
            r_cnt    <= ONE_CNT;
            r_hi_cap <= '0;
          end else if (r_cnt == MAX_CNT) begin
            r_timeout <= 1'b1;
            r_locked  <= 1'b0;
            r_state   <= ST_IDLE;
          end else begin
            // The count keeps running through a fall so that period_out equals P exactly.
            if (w_fall) begin
              r_hi_cap <= r_cnt;
            end
            r_cnt <= r_cnt + ONE_CNT;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tick       = r_tick;
  assign period_out = r_period;
  assign high_out   = r_high;
  assign valid      = r_valid;
  assign locked     = r_locked;
  assign glitch     = r_glitch;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_tick_period_meter.sv
// Directed self-checking bench for tick_period_meter (MIN_PERIOD=4, MAX_PERIOD=100).
module tb_tick_period_meter;

  localparam int CNT_W = 27;
  localparam int MINP  = 4;
  localparam int MAXP  = 100;
`ifdef TICK_METER_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic             clock_in;
  logic             reset_n;
  logic             sig_in;
  logic             tick;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] high_out;
  logic             valid;
  logic             locked;
  logic             glitch;
  logic             timeout;

  int    n_checks;
  int    n_errors;
  string g_tag;

  tick_period_meter #(
    .CNT_W      (CNT_W),
    .MIN_PERIOD (MINP),
    .MAX_PERIOD (MAXP)
  ) dut (
    .clock_in   (clock_in),
    .reset_n    (reset_n),
    .sig_in     (sig_in),
    .tick       (tick),
    .period_out (period_out),
    .high_out   (high_out),
    .valid      (valid),
    .locked     (locked),
    .glitch     (glitch),
    .timeout    (timeout)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  // Advance to just after the next rising edge; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  // One period of sig_in: high for h clocks, low for p-h. Checks the pulses caused by this
  // period's opening rise, which appear LAT clocks after it is driven.
  task automatic run_period(input int h, input int p, input bit exp_v, input bit exp_g,
                            input int exp_per, input int exp_hi);
    bit e_tick;
    sig_in = 1'b1;
    for (int i = 1; i <= p; i++) begin
      step();
      if (i == h) sig_in = 1'b0;
      e_tick = (i == LAT);
      n_checks++;
      if (tick !== e_tick) begin
        n_errors++;
        $display("FAIL %s tick step %0d: got %b expected %b", g_tag, i, tick, e_tick);
      end
      n_checks++;
      if (valid !== (e_tick & exp_v)) begin
        n_errors++;
        $display("FAIL %s valid step %0d: got %b expected %b", g_tag, i, valid, e_tick & exp_v);
      end
      n_checks++;
      if (glitch !== (e_tick & exp_g)) begin
        n_errors++;
        $display("FAIL %s glitch step %0d: got %b expected %b", g_tag, i, glitch,
                 e_tick & exp_g);
      end
      if (e_tick && exp_v) begin
        n_checks++;
        if (period_out !== CNT_W'(exp_per)) begin
          n_errors++;
          $display("FAIL %s period_out: got %0d expected %0d", g_tag, period_out, exp_per);
        end
        n_checks++;
        if (high_out !== CNT_W'(exp_hi)) begin
          n_errors++;
          $display("FAIL %s high_out: got %0d expected %0d", g_tag, high_out, exp_hi);
        end
      end
    end
  endtask

  task automatic test_reset();
    g_tag   = "reset";
    reset_n = 1'b0;
    sig_in  = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({tick, valid, locked, glitch, timeout} !== 5'b0 || period_out !== '0 ||
        high_out !== '0) begin
      n_errors++;
      $display("FAIL reset outputs: got t%b v%b l%b g%b to%b p%0d h%0d expected all 0",
               tick, valid, locked, glitch, timeout, period_out, high_out);
    end
    reset_n = 1'b1;
    repeat (5) step();
    g_tag = "first_edge";
    run_period(20, 40, 1'b0, 1'b0, 0, 0);
    n_checks++;
    if (locked !== 1'b0) begin
      n_errors++;
      $display("FAIL first_edge locked: got %b expected 0", locked);
    end
  endtask

  task automatic test_clean();
    g_tag = "clean";
    for (int n = 0; n < 5; n++) begin
      run_period(20, 40, 1'b1, 1'b0, 40, 20);
      n_checks++;
      if (locked !== 1'b1) begin
        n_errors++;
        $display("FAIL clean locked period %0d: got %b expected 1", n, locked);
      end
    end
  endtask

  task automatic test_glitch();
    g_tag = "glitch_a";
    run_period(1, 3, 1'b1, 1'b0, 40, 20);
    g_tag = "glitch_b";
    run_period(20, 40, 1'b0, 1'b1, 0, 0);
    n_checks++;
    if (locked !== 1'b0) begin
      n_errors++;
      $display("FAIL glitch locked: got %b expected 0", locked);
    end
    n_checks++;
    if (period_out !== CNT_W'(40)) begin
      n_errors++;
      $display("FAIL glitch period_hold: got %0d expected 40", period_out);
    end
    g_tag = "glitch_recover";
    run_period(20, 40, 1'b1, 1'b0, 40, 20);
    n_checks++;
    if (locked !== 1'b1) begin
      n_errors++;
      $display("FAIL glitch_recover locked: got %b expected 1", locked);
    end
  endtask

  task automatic test_duty();
    g_tag = "duty_old";
    run_period(30, 40, 1'b1, 1'b0, 40, 20);
    g_tag = "duty_new";
    run_period(30, 40, 1'b1, 1'b0, 40, 30);
  endtask

  task automatic test_timeout();
    g_tag  = "timeout";
    sig_in = 1'b1;
    for (int i = 1; i <= LAT + MAXP; i++) begin
      step();
      if (i == 20) sig_in = 1'b0;
      if (i == LAT) begin
        n_checks++;
        if (valid !== 1'b1 || high_out !== CNT_W'(30)) begin
          n_errors++;
          $display("FAIL timeout last_valid: got v%b h%0d expected v1 h30", valid, high_out);
        end
      end
      if (i == LAT + MAXP - 1) begin
        n_checks++;
        if (timeout !== 1'b0 || locked !== 1'b1) begin
          n_errors++;
          $display("FAIL timeout early: got to%b l%b expected to0 l1", timeout, locked);
        end
      end
    end
    n_checks++;
    if (timeout !== 1'b1 || locked !== 1'b0) begin
      n_errors++;
      $display("FAIL timeout assert: got to%b l%b expected to1 l0", timeout, locked);
    end
    repeat (10) step();
    n_checks++;
    if (timeout !== 1'b1 || period_out !== CNT_W'(40)) begin
      n_errors++;
      $display("FAIL timeout sticky: got to%b p%0d expected to1 p40", timeout, period_out);
    end
    g_tag = "timeout_rearm";
    run_period(20, 40, 1'b0, 1'b0, 0, 0);
    n_checks++;
    if (timeout !== 1'b0 || locked !== 1'b0) begin
      n_errors++;
      $display("FAIL timeout clear: got to%b l%b expected to0 l0", timeout, locked);
    end
    g_tag = "timeout_resume";
    run_period(20, 40, 1'b1, 1'b0, 40, 20);
  endtask

  task automatic test_reset_mid();
    g_tag  = "reset_mid";
    sig_in = 1'b1;
    repeat (15) step();
    reset_n = 1'b0;
    sig_in  = 1'b0;
    #1;
    n_checks++;
    if ({tick, valid, locked, glitch, timeout} !== 5'b0 || period_out !== '0 ||
        high_out !== '0) begin
      n_errors++;
      $display("FAIL reset_mid async: got l%b p%0d h%0d expected all 0", locked, period_out,
               high_out);
    end
    repeat (3) step();
    reset_n = 1'b1;
    repeat (5) step();
    g_tag = "reset_mid_arm";
    run_period(20, 40, 1'b0, 1'b0, 0, 0);
    n_checks++;
    if (locked !== 1'b0 || period_out !== '0) begin
      n_errors++;
      $display("FAIL reset_mid_arm: got l%b p%0d expected l0 p0", locked, period_out);
    end
    g_tag = "reset_mid_first";
    run_period(20, 40, 1'b1, 1'b0, 40, 20);
    n_checks++;
    if (locked !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_mid locked: got %b expected 1", locked);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    sig_in   = 1'b0;
    test_reset();
    test_clean();
`ifndef TICK_METER_GLITCH_FILTER_EN
    test_glitch();
`endif
    test_duty();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tick_period_meter.md
# tick_period_meter

Measures the period and high time of a slow, asynchronous square wave, such as a divided game or animation tick from a clock divider, in cycles of the system clock. It resynchronises the input and reports a captured measurement with a one-cycle valid pulse. It also flags glitches (periods that are too short) and loss of signal (timeout). The block sits on the consumer side of the tick path and gives game logic a checked tick plus its measured rate.

## Interface
- CNT_W, 27: width of all cycle counters and measurement outputs.
- MIN_PERIOD, 27'd4: shortest period accepted as valid, in clocks.
- MAX_PERIOD, 27'd720000: cycles with no rising edge before a timeout is declared; must satisfy MIN_PERIOD < MAX_PERIOD < 2^CNT_W.
- clock_in  input  1  system clock; all flops update on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- sig_in  input  1  asynchronous square wave to measure.
- tick  output  1  one-cycle pulse on each synchronised rising edge of sig_in.
- period_out  output  CNT_W  last accepted period, in clocks.
- high_out  output  CNT_W  high time of the last accepted period, in clocks.
- valid  output  1  one-cycle pulse when period_out and high_out update.
- locked  output  1  high while accepted periods keep arriving.
- glitch  output  1  one-cycle pulse when a period shorter than MIN_PERIOD is rejected.
- timeout  output  1  sticky loss-of-signal flag.

## Operation
- Reset values: all outputs 0, counter 0, state IDLE, synchroniser flops 0.
- Synchroniser:
  - sig_in passes through two flops to give s_sync; s_prev is s_sync delayed one cycle.
  - rise = s_sync & ~s_prev; fall = ~s_sync & s_prev.
- FSM states:
  - IDLE: waits for the first rise. No measurement is taken.
  - RUN: a period is in progress.
- IDLE to RUN on rise: cnt <= 1, hi_cap <= 0, timeout <= 0.
- In RUN, each cycle with no edge: cnt <= cnt + 1, saturating at MAX_PERIOD.
- In RUN on fall: hi_cap <= cnt.
- In RUN on rise, with cnt >= MIN_PERIOD:
  - period_out <= cnt, high_out <= hi_cap, valid pulses, locked <= 1.
  - Then cnt <= 1 and hi_cap <= 0.
- In RUN on rise, with cnt < MIN_PERIOD:
  - glitch pulses and outputs are held.
  - locked <= 0, cnt <= 1, hi_cap <= 0.
- In RUN, when cnt == MAX_PERIOD and there is no rise:
  - timeout <= 1, locked <= 0, go to IDLE.
  - period_out and high_out hold their last values.
- tick pulses on every rise in either state. It is independent of accept or reject.
- rise and fall can never be detected in the same cycle.
- Result of the count rule: a clean square wave with period P and high time H gives period_out = P and high_out = H exactly.
- The timeout flag stays set until the next rise or reset.
- Reset asserted mid-period discards the partial count. The first rise after reset only arms the FSM; no valid is issued for it.

## Timing
- sig_in high at clock edge k (first sample) gives rise in the cycle after edge k+1.
- tick, valid and glitch are registered and assert after edge k+2. Latency is 3 clocks from the sampled input edge.
- Outputs are registered; none has a combinational path from sig_in.
- valid and glitch are mutually exclusive. Each is high for exactly one cycle.
- timeout asserts the cycle after cnt reaches MAX_PERIOD, i.e. MAX_PERIOD + 1 clocks after the last rise was detected.

## Configuration
- TICK_METER_GLITCH_FILTER_EN, when defined:
  - A 3-sample majority filter is inserted between s_sync and s_prev.
  - Pulses one clock wide on sig_in are suppressed.
  - Latency from sampled edge to tick or valid becomes 5 clocks.
  - Measured P and H are unchanged for clean inputs.
- When not defined, there is no filter, latency is 3 clocks, and any pulse of two or more clocks is detected.

## Structure
- A shared package holds:
  - the FSM state encoding: ST_IDLE = 1'b0, ST_RUN = 1'b1;
  - default CNT_W, MIN_PERIOD and MAX_PERIOD constants, with MAX_PERIOD defaulting to twice the standard divider period of 360000.
- One sub-module, tick_sync_edge, contains the synchroniser, the optional majority filter, s_prev, and the rise and fall outputs.
- The counter, FSM and capture registers live in tick_period_meter.

## Test plan
- Bench parameters are MIN_PERIOD=4, MAX_PERIOD=100 unless a scenario says otherwise.
- Reset and first edge: hold reset_n low, then release.
  - All outputs read 0.
  - The first sig_in rise gives tick only; valid stays 0 and locked stays 0.
- Clean wave: P=40, H=20, run 5 periods.
  - valid pulses every 40 clocks, period_out=40, high_out=20, locked=1 after the first accepted period.
  - tick and valid occur 3 clocks after each sampled rise (5 clocks with the filter macro).
- Glitch: 2-clock low gap (high, low for 2, high) inside a P=40 wave, where the glitch rise arrives 3 clocks after a valid rise.
  - glitch pulses, locked drops to 0, period_out stays 40.
  - The next full period restores valid and locked.
- Timeout: hold sig_in low after a rise.
  - timeout=1 exactly 101 clocks after that rise's detection; locked=0.
  - The next rise clears timeout and produces no valid.
- Duty change: switch from H=20 to H=30 with P=40 held.
  - high_out changes from 20 to 30 on the valid of the first full period with the new duty.
- Reset mid-period: assert reset_n low 15 clocks into a period.
  - All outputs go to 0 immediately, with no clock required.
  - After release, the first valid comes only after a complete armed period.
